// File: rtl/counter_run_sequencer.sv
// Run sequencer for a cen/rst counter datapath: clear the counters, issue a
// programmed number of prescaled enable pulses, then pulse done.
module counter_run_sequencer #(
  parameter int CNT_W      = 16,
  parameter int DIV_W      = 8,
  parameter int CLR_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             free_run,
  input  logic [CNT_W-1:0] run_len,
  input  logic [DIV_W-1:0] div,
  output logic             busy,
  output logic             done,
  output logic             cnt_rst,
  output logic             cnt_cen,
  output logic [CNT_W-1:0] en_count
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CLR_W-1:0] clr_q, clr_d;
  logic [DIV_W-1:0] pre_q, pre_d, pre_nxt;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             free_q, free_d;
  logic [CNT_W-1:0] en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rst_q, rst_d;
  logic             cen_q, cen_d;

  // Next-state and next-output logic; cen is decided one cycle ahead so it can be registered.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    pre_d   = pre_q;
    div_d   = div_q;
    len_d   = len_q;
    free_d  = free_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rst_d   = 1'b0;
    cen_d   = 1'b0;
    pre_nxt = cen_q ? {DIV_W{1'b0}} : pre_q + DIV_W'(1);

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && !abort) begin
          div_d   = div;
          len_d   = run_len;
          free_d  = free_run;
          en_d    = {CNT_W{1'b0}};
          clr_d   = {CLR_W{1'b0}};
          state_d = S_CLEAR;
          busy_d  = 1'b1;
          rst_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (clr_q == CLR_LAST) begin
          if (free_q || (len_q != {CNT_W{1'b0}})) begin
            state_d = S_RUN;
            pre_d   = {DIV_W{1'b0}};
            cen_d   = (div_q == {DIV_W{1'b0}});
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          clr_d  = clr_q + CLR_W'(1);
          rst_d  = 1'b1;
          busy_d = 1'b1;
        end
      end
      S_RUN: begin
        // A pulse already on the wire is counted even if this cycle aborts.
        if (cen_q) begin
          en_d = en_q + CNT_W'(1);
        end else begin
          en_d = en_q;
        end
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cen_q && !free_q && ((en_q + CNT_W'(1)) == len_q)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          pre_d  = pre_nxt;
          cen_d  = (pre_nxt == div_q);
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      clr_q   <= {CLR_W{1'b0}};
      pre_q   <= {DIV_W{1'b0}};
      div_q   <= {DIV_W{1'b0}};
      len_q   <= {CNT_W{1'b0}};
      free_q  <= 1'b0;
      en_q    <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rst_q   <= 1'b0;
      cen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      pre_q   <= pre_d;
      div_q   <= div_d;
      len_q   <= len_d;
      free_q  <= free_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rst_q   <= rst_d;
      cen_q   <= cen_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign cnt_rst  = rst_q;
  assign cnt_cen  = cen_q;
  assign en_count = en_q;

endmodule

// File: tb/tb_counter_run_sequencer.sv
// Scoreboard bench for counter_run_sequencer: expected per-cycle outputs come
// from an arithmetic run-timeline model and are checked by a separate monitor.
module tb_counter_run_sequencer;

  localparam int CNT_W = 4;
  localparam int DIV_W = 8;
  localparam int C     = 4;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, free_run;
  logic [CNT_W-1:0] run_len;
  logic [DIV_W-1:0] div;
  logic             busy, done, cnt_rst, cnt_cen;
  logic [CNT_W-1:0] en_count;

  counter_run_sequencer #(.CNT_W(CNT_W), .DIV_W(DIV_W), .CLR_CYCLES(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .free_run(free_run),
    .run_len(run_len), .div(div), .busy(busy), .done(done), .cnt_rst(cnt_rst),
    .cnt_cen(cnt_cen), .en_count(en_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             rst;
    logic             cen;
    logic [CNT_W-1:0] en;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;
  int   checks = 0;
  int   errors = 0;
  logic [CNT_W-1:0] last_en = '0;

  // Current transaction: length, divider, free-run, abort edge, reset edge (0 = none).
  int t_l, t_d, t_f, t_a, t_rs;

  function automatic int done_cycle();
    return (t_f != 0) ? (1 << 30) : C + 1 + t_l * (t_d + 1);
  endfunction

  function automatic exp_t idle_exp(logic [CNT_W-1:0] en);
    exp_t x;
    x = '0;
    x.en = en;
    return x;
  endfunction

  // Expected outputs during cycle t+j, where the start was sampled at edge t.
  function automatic exp_t exp_at(int j);
    exp_t x;
    int   e, m, n;
    e = done_cycle();
    x = '0;
    if (t_rs != 0 && j > t_rs) begin
      x = '0;
    end else if (t_a != 0 && t_a < e && j > t_a) begin
      n = (t_a >= C + 1) ? (t_a - C) / (t_d + 1) : 0;
      x.en = CNT_W'(n);
    end else if (j == e) begin
      x.done = 1'b1;
      x.en = CNT_W'(t_l);
    end else if (j > e) begin
      x.en = CNT_W'(t_l);
    end else if (j <= C) begin
      x.busy = 1'b1;
      x.rst = 1'b1;
    end else begin
      m = j - C - 1;
      x.busy = 1'b1;
      x.cen = ((m % (t_d + 1)) == t_d);
      x.en = CNT_W'(m / (t_d + 1));
    end
    return x;
  endfunction

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      abort = ($urandom_range(0, 1) == 1);
      start = abort && ($urandom_range(0, 1) == 1);
      run_len = CNT_W'($urandom);
      div = DIV_W'($urandom_range(0, 3));
      @(posedge clk);
      exp_q.push_back(idle_exp(last_en));
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_txn(int l, int d, int f, int a, int rs, bit noise);
    int e, last;
    t_l = l; t_d = d; t_f = f; t_a = a; t_rs = rs;
    e = done_cycle();
    last = (rs != 0) ? rs + 1 : ((a != 0 && a < e) ? a + 1 : e + 1);
    start = 1'b1; abort = 1'b0; free_run = f[0];
    run_len = CNT_W'(l); div = DIV_W'(d);
    @(posedge clk);
    exp_q.push_back(exp_at(1));
    #1;
    for (int j = 1; j < last; j++) begin
      start = noise && ($urandom_range(0, 1) == 1);
      abort = (j == a);
      rst_n = !(j == rs);
      if (noise) begin
        free_run = ($urandom_range(0, 1) == 1);
        run_len = CNT_W'($urandom);
        div = DIV_W'($urandom);
      end
      @(posedge clk);
      exp_q.push_back(exp_at(j + 1));
      #1;
    end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    last_en = exp_at(last).en;
  endtask

  // Monitor: one expected entry per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      checks++;
      if ({busy, done, cnt_rst, cnt_cen, en_count} !== mon_x) begin
        errors++;
        $display("FAIL outputs @%0t got busy=%b done=%b rst=%b cen=%b en=%0d want busy=%b done=%b rst=%b cen=%b en=%0d",
                 $time, busy, done, cnt_rst, cnt_cen, en_count,
                 mon_x.busy, mon_x.done, mon_x.rst, mon_x.cen, mon_x.en);
      end
    end
  end

  initial begin
    int l, d, f, a, rs, e;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; free_run = 1'b0;
    run_len = '0; div = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      exp_q.push_back(idle_exp('0));
      #1;
    end
    rst_n = 1'b1;
    idle(3);
    run_txn(5, 0, 0, 0, 0, 1'b0);
    idle(2);
    run_txn(3, 3, 0, 0, 0, 1'b0);
    idle(2);
    run_txn(0, 0, 0, 0, 0, 1'b0);
    idle(2);
    run_txn(15, 0, 0, C + 10, 0, 1'b0);
    idle(2);
    run_txn(0, 0, 1, 40, 0, 1'b1);
    idle(2);
    run_txn(7, 1, 1, 0, 12, 1'b0);
    idle(1);
    run_txn(4, 2, 0, 0, 0, 1'b0);
    idle(3);
    for (int k = 0; k < 40; k++) begin
      l = $urandom_range(0, 15);
      d = $urandom_range(0, 4);
      f = ($urandom_range(0, 7) == 0) ? 1 : 0;
      t_l = l; t_d = d; t_f = f;
      e = done_cycle();
      a = 0;
      rs = 0;
      if (f != 0) begin
        a = $urandom_range(1, 60);
      end else if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(1, e - 1);
      end else if ($urandom_range(0, 9) == 0) begin
        rs = $urandom_range(1, e - 1);
      end
      run_txn(l, d, f, a, rs, 1'b1);
      idle($urandom_range(1, 4));
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
